shift_rs: RTL

//  Reservation station in front of the shift functional unit. Holds dispatched shift

---
 rtl/shift_rs_if.sv | 60 ++++++
 rtl/shift_rs.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_rs_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_rs_if
//  Description : Dispatch / CDB / FU-issue bundle for the shift reservation
//                station. The slave modport is the station itself; the master
//                modport is the surrounding pipeline (dispatch, CDB, FU).
//  Revision    : 1.0  initial release
// ============================================================================
interface shift_rs_if #(
    parameter int TAG_W = 4
) ();
    // Dispatch side
    logic                       dispatch_valid;
    logic                       dispatch_ready;
    logic [7:0]                 dispatch_operand;
    logic [1:0][7:0]            dispatch_depvals;
    logic [1:0][TAG_W-1:0]      dispatch_deptags;
    logic [1:0]                 dispatch_depready;
    logic [7:0]                 dispatch_wbs;
    logic [7:0]                 dispatch_flags;
    logic [TAG_W-1:0]           dispatch_robid;

    // Common data bus snoop
    logic                       cdb_valid;
    logic [TAG_W-1:0]           cdb_id;
    logic [7:0]                 cdb_val;

    // Functional-unit control and issue
    logic                       fu_busy;
    logic                       flush;
    logic                       issue_transmit;
    logic [7:0]                 issue_operand;
    logic [1:0][7:0]            issue_depvals;
    logic [7:0]                 issue_wbs;
    logic [7:0]                 issue_flags;
    logic [TAG_W-1:0]           issue_robid;

    modport slave (
        input  dispatch_valid, dispatch_operand, dispatch_depvals,
               dispatch_deptags, dispatch_depready, dispatch_wbs,
               dispatch_flags, dispatch_robid,
        input  cdb_valid, cdb_id, cdb_val,
        input  fu_busy, flush,
        output dispatch_ready,
        output issue_transmit, issue_operand, issue_depvals,
               issue_wbs, issue_flags, issue_robid
    );

    modport master (
        output dispatch_valid, dispatch_operand, dispatch_depvals,
               dispatch_deptags, dispatch_depready, dispatch_wbs,
               dispatch_flags, dispatch_robid,
        output cdb_valid, cdb_id, cdb_val,
        output fu_busy, flush,
        input  dispatch_ready,
        input  issue_transmit, issue_operand, issue_depvals,
               issue_wbs, issue_flags, issue_robid
    );
endinterface
`default_nettype wire

// File: rtl/shift_rs.sv
`default_nettype none
// ============================================================================
//  Module      : shift_rs
//  Description : Reservation station for the shift functional unit. Holds
//                dispatched uops until both sources are known (snooping the
//                CDB), then issues the lowest-index ready uop, one per cycle,
//                whenever the FU is not busy.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    shift_rs_if.slave   bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // ------------------------------------------------------------------
    // Entry storage
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]                   valid_q,   valid_d;
    logic [DEPTH-1:0][7:0]              operand_q, operand_d;
    logic [DEPTH-1:0][7:0]              wbs_q,     wbs_d;
    logic [DEPTH-1:0][7:0]              flags_q,   flags_d;
    logic [DEPTH-1:0][TAG_W-1:0]        robid_q,   robid_d;
    logic [DEPTH-1:0][1:0][7:0]         val_q,     val_d;
    logic [DEPTH-1:0][1:0][TAG_W-1:0]   tag_q,     tag_d;
    logic [DEPTH-1:0][1:0]              rdy_q,     rdy_d;

    // Issue output registers
    logic                               issue_transmit_q, issue_transmit_d;
    logic [7:0]                         issue_operand_q,  issue_operand_d;
    logic [1:0][7:0]                    issue_depvals_q,  issue_depvals_d;
    logic [7:0]                         issue_wbs_q,      issue_wbs_d;
    logic [7:0]                         issue_flags_q,    issue_flags_d;
    logic [TAG_W-1:0]                   issue_robid_q,    issue_robid_d;

    // Selection wires
    logic [DEPTH-1:0]                   w_cand;
    logic [DEPTH-1:0]                   w_free;
    logic                               w_any_cand;
    logic [IDX_W-1:0]                   w_cand_idx;
    logic [IDX_W-1:0]                   w_free_idx;
    logic                               w_dispatch_ready;
    logic                               w_accept;
    logic                               w_issue;

    // Per-entry candidate / free flags, purely from registered state so a
    // source woken this cycle only becomes eligible next cycle.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign w_cand[gi] = valid_q[gi] & rdy_q[gi][0] & rdy_q[gi][1];
            assign w_free[gi] = ~valid_q[gi];
        end
    endgenerate

    // Full check ignores a slot freed by this cycle's issue.
    assign w_dispatch_ready = ~(&valid_q);
    assign w_any_cand       = |w_cand;
    assign w_accept         = bus.dispatch_valid & w_dispatch_ready & ~bus.flush;
    assign w_issue          = w_any_cand & ~bus.fu_busy & ~bus.flush;

    // Lowest-index priority encoders for issue pick and allocation.
    always_comb begin
        w_cand_idx = '0;
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_cand[i]) w_cand_idx = IDX_W'(i);
            if (w_free[i]) w_free_idx = IDX_W'(i);
        end
    end

    // Entry next-state: wakeup, issue release, allocation, then flush override.
    always_comb begin
        valid_d   = valid_q;
        operand_d = operand_q;
        wbs_d     = wbs_q;
        flags_d   = flags_q;
        robid_d   = robid_q;
        val_d     = val_q;
        tag_d     = tag_q;
        rdy_d     = rdy_q;

        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < 2; s++) begin
                if (valid_q[i] && !rdy_q[i][s] && bus.cdb_valid &&
                    (bus.cdb_id == tag_q[i][s])) begin
                    val_d[i][s] = bus.cdb_val;
                    rdy_d[i][s] = 1'b1;
                end
            end
        end

        if (w_issue) begin
            valid_d[w_cand_idx] = 1'b0;
        end

        // The allocated slot is free in registered state, so it never
        // collides with the issued slot or with a wakeup above.
        if (w_accept) begin
            valid_d[w_free_idx]   = 1'b1;
            operand_d[w_free_idx] = bus.dispatch_operand;
            wbs_d[w_free_idx]     = bus.dispatch_wbs;
            flags_d[w_free_idx]   = bus.dispatch_flags;
            robid_d[w_free_idx]   = bus.dispatch_robid;
            for (int s = 0; s < 2; s++) begin
                tag_d[w_free_idx][s] = bus.dispatch_deptags[s];
                if (bus.dispatch_depready[s]) begin
                    val_d[w_free_idx][s] = bus.dispatch_depvals[s];
                    rdy_d[w_free_idx][s] = 1'b1;
                end else if (bus.cdb_valid &&
                             (bus.cdb_id == bus.dispatch_deptags[s])) begin
                    // Producer is broadcasting right now: capture it here,
                    // otherwise the value would be missed forever.
                    val_d[w_free_idx][s] = bus.cdb_val;
                    rdy_d[w_free_idx][s] = 1'b1;
                end else begin
                    val_d[w_free_idx][s] = bus.dispatch_depvals[s];
                    rdy_d[w_free_idx][s] = 1'b0;
                end
            end
        end

        if (bus.flush) begin
            valid_d = '0;
        end
    end

    // Issue register next-state: load the picked entry, otherwise hold fields.
    always_comb begin
        issue_transmit_d = w_issue;
        issue_operand_d  = issue_operand_q;
        issue_depvals_d  = issue_depvals_q;
        issue_wbs_d      = issue_wbs_q;
        issue_flags_d    = issue_flags_q;
        issue_robid_d    = issue_robid_q;
        if (w_issue) begin
            issue_operand_d = operand_q[w_cand_idx];
            issue_depvals_d = val_q[w_cand_idx];
            issue_wbs_d     = wbs_q[w_cand_idx];
            issue_flags_d   = flags_q[w_cand_idx];
            issue_robid_d   = robid_q[w_cand_idx];
        end
    end

    // Entry state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            operand_q <= '0;
            wbs_q     <= '0;
            flags_q   <= '0;
            robid_q   <= '0;
            val_q     <= '0;
            tag_q     <= '0;
            rdy_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            operand_q <= operand_d;
            wbs_q     <= wbs_d;
            flags_q   <= flags_d;
            robid_q   <= robid_d;
            val_q     <= val_d;
            tag_q     <= tag_d;
            rdy_q     <= rdy_d;
        end
    end

    // Issue output registers; reset drops any in-flight issue immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_transmit_q <= 1'b0;
            issue_operand_q  <= '0;
            issue_depvals_q  <= '0;
            issue_wbs_q      <= '0;
            issue_flags_q    <= '0;
            issue_robid_q    <= '0;
        end else begin
            issue_transmit_q <= issue_transmit_d;
            issue_operand_q  <= issue_operand_d;
            issue_depvals_q  <= issue_depvals_d;
            issue_wbs_q      <= issue_wbs_d;
            issue_flags_q    <= issue_flags_d;
            issue_robid_q    <= issue_robid_d;
        end
    end

    assign bus.dispatch_ready = w_dispatch_ready;
    assign bus.issue_transmit = issue_transmit_q;
    assign bus.issue_operand  = issue_operand_q;
    assign bus.issue_depvals  = issue_depvals_q;
    assign bus.issue_wbs      = issue_wbs_q;
    assign bus.issue_flags    = issue_flags_q;
    assign bus.issue_robid    = issue_robid_q;

endmodule
`default_nettype wire
